lif_neuron_array: RTL and testbench

Parametrised array of leaky integrate-and-fire neurons: the multi-channel successor to the single-neuron membrane block behind the tiny-tapeout top level. Each channel integrates an unsigned synaptic input into a saturating membrane register, applies a shift-based leak, and emits a one-cycle spike pulse on a threshold crossing. An optional refractory period holds the membrane at rest after each spike. It sits between the input switch/bus decode and the display or GPIO output mux.

---
 rtl/lif_neuron_array.sv | 132 +++++++++++++
 tb/tb_lif_neuron_array.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons, one lif_neuron_lane per channel.
// Define REFRACTORY_EN to build the per-channel refractory mode and rc counter.
module lif_neuron_lane #(
   parameter int WIDTH      = 8,
   parameter int THRESHOLD  = 200,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRACT    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] syn_i,
   output logic [WIDTH-1:0] v_o,
   output logic             spike_o
);
   localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

   logic [WIDTH-1:0] v_q, v_d;
   logic             spike_q, spike_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sat;
   logic             fire, integ;

   // One spare bit holds the worst case (2^WIDTH-1) + (2^WIDTH-1); leak never underflows.
   assign sum  = {1'b0, v_q} - {1'b0, v_q >> LEAK_SHIFT} + {1'b0, syn_i};
   assign sat  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
   assign fire = (sat >= THR);

`ifdef REFRACTORY_EN
   typedef enum logic {INTEGRATE, REFRACTORY} mode_e;
   localparam logic [7:0] RC_INIT = 8'(REFRACT);

   mode_e      mode_q, mode_d;
   logic [7:0] rc_q, rc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= INTEGRATE;
         rc_q   <= 8'd0;
      end else begin
         mode_q <= mode_d;
         rc_q   <= rc_d;
      end
   end

   // Leaving REFRACTORY happens on the edge rc hits 0; the next enabled edge integrates.
   always_comb begin
      mode_d = mode_q;
      rc_d   = rc_q;
      if (en) begin
         case (mode_q)
            INTEGRATE: begin
               if (fire) begin
                  mode_d = REFRACTORY;
                  rc_d   = RC_INIT;
               end
            end
            REFRACTORY: begin
               rc_d = rc_q - 8'd1;
               if (rc_q == 8'd1) mode_d = INTEGRATE;
            end
            default: mode_d = INTEGRATE;
         endcase
      end
   end

   assign integ = (mode_q == INTEGRATE);
`else
   assign integ = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q     <= '0;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         spike_q <= spike_d;
      end
   end

   always_comb begin
      v_d     = v_q;
      spike_d = 1'b0;
      if (en) begin
         if (!integ) begin
            v_d = '0;
         end else if (fire) begin
            v_d     = '0;
            spike_d = 1'b1;
         end else begin
            v_d = sat;
         end
      end
   end

   assign v_o     = v_q;
   assign spike_o = spike_q;
endmodule

module lif_neuron_array #(
   parameter int WIDTH      = 8,
   parameter int N_CH       = 4,
   parameter int THRESHOLD  = 200,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRACT    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [N_CH*WIDTH-1:0] I_syn,
   output logic [N_CH*WIDTH-1:0] V_mem,
   output logic [N_CH-1:0]       spike
);
   logic [N_CH-1:0][WIDTH-1:0] syn, vm;

   assign syn   = I_syn;
   assign V_mem = vm;

   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      lif_neuron_lane #(
         .WIDTH(WIDTH), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT(REFRACT)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .en     (en),
         .syn_i  (syn[k]),
         .v_o    (vm[k]),
         .spike_o(spike[k])
      );
   end
endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: default instance plus a THRESHOLD=255 instance
// for saturation; expectations follow REFRACTORY_EN when it is defined.
module tb_lif_neuron_array;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [31:0] I_syn = '0, I_syn2 = '0;
   logic [31:0] V_mem, V_mem2;
   logic [3:0]  spike, spike2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] v;
      logic [3:0]  sp;
      logic [31:0] v2;
      logic [3:0]  sp2;
      string       tag;
   } exp_t;

   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;

   lif_neuron_array dut (
      .clk(clk), .reset(reset), .en(en), .I_syn(I_syn), .V_mem(V_mem), .spike(spike)
   );

   lif_neuron_array #(.THRESHOLD(255)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .I_syn(I_syn2), .V_mem(V_mem2), .spike(spike2)
   );

   function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
   endfunction

   task automatic step(input logic e_i, input logic [31:0] syn, input logic [31:0] syn2,
                       input logic [31:0] v, input logic [3:0] sp,
                       input logic [31:0] v2, input logic [3:0] sp2, input string tag);
      exp_t x;
      @(negedge clk);
      en     = e_i;
      I_syn  = syn;
      I_syn2 = syn2;
      x.v = v; x.sp = sp; x.v2 = v2; x.sp2 = sp2; x.tag = tag;
      q.push_back(x);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Monitor: each expectation describes the outputs after the next rising edge.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (V_mem !== e.v || spike !== e.sp || V_mem2 !== e.v2 || spike2 !== e.sp2) begin
            bad++;
            $display("FAIL %s: V_mem=%h spike=%b V2=%h sp2=%b want V_mem=%h spike=%b V2=%h sp2=%b",
                     e.tag, V_mem, spike, V_mem2, spike2, e.v, e.sp, e.v2, e.sp2);
         end
      end
   end

   initial begin
      #3;
      chk("reset_vmem", V_mem, 32'h0);
      chk("reset_spike", {28'h0, spike}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      step(1, pk(50,0,0,0), pk(0,200,0,0), pk(50,0,0,0), 4'b0000, pk(0,200,0,0), 4'b0000, "int1");
      step(1, pk(50,0,0,0), pk(0,255,0,0), pk(94,0,0,0), 4'b0000, 32'h0, 4'b0010, "int2_sat");
      step(1, pk(50,0,0,0), 32'h0, pk(133,0,0,0), 4'b0000, 32'h0, 4'b0000, "int3");
      for (int i = 0; i < 3; i++)
         step(0, pk(50,0,0,0), 32'h0, pk(133,0,0,0), 4'b0000, 32'h0, 4'b0000, "gate_hold");
      step(1, pk(50,0,0,0), 32'h0, pk(167,0,0,0), 4'b0000, 32'h0, 4'b0000, "int4");
      step(1, pk(50,0,0,0), 32'h0, pk(197,0,0,0), 4'b0000, 32'h0, 4'b0000, "int5");
      step(1, pk(50,0,0,0), 32'h0, 32'h0, 4'b0001, 32'h0, 4'b0000, "fire6");
`ifdef REFRACTORY_EN
      step(1, pk(50,0,0,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "refr1");
      step(1, pk(50,0,0,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "refr2");
      step(0, pk(50,0,0,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "refr_gate1");
      step(0, pk(50,0,0,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "refr_gate2");
      step(1, pk(50,0,0,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "refr3");
      step(1, pk(50,0,0,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "refr4");
      step(1, pk(50,0,0,0), 32'h0, pk(50,0,0,0), 4'b0000, 32'h0, 4'b0000, "resume");
`else
      step(1, pk(50,0,0,0), 32'h0, pk(50,0,0,0), 4'b0000, 32'h0, 4'b0000, "post1");
      step(1, pk(50,0,0,0), 32'h0, pk(94,0,0,0), 4'b0000, 32'h0, 4'b0000, "post2");
      step(0, pk(50,0,0,0), 32'h0, pk(94,0,0,0), 4'b0000, 32'h0, 4'b0000, "post_gate1");
      step(0, pk(50,0,0,0), 32'h0, pk(94,0,0,0), 4'b0000, 32'h0, 4'b0000, "post_gate2");
      step(1, pk(50,0,0,0), 32'h0, pk(133,0,0,0), 4'b0000, 32'h0, 4'b0000, "post3");
      step(1, pk(50,0,0,0), 32'h0, pk(167,0,0,0), 4'b0000, 32'h0, 4'b0000, "post4");
      step(1, pk(50,0,0,0), 32'h0, pk(197,0,0,0), 4'b0000, 32'h0, 4'b0000, "post5");
`endif
      step(1, pk(255,255,255,255), 32'h0, 32'h0, 4'b1111, 32'h0, 4'b0000, "all_fire");
      for (int i = 0; i < 4; i++)
         step(1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "quiet");
      step(1, pk(0,0,200,0), 32'h0, 32'h0, 4'b0100, 32'h0, 4'b0000, "b2b1");
`ifdef REFRACTORY_EN
      step(1, pk(0,0,200,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "b2b2");
      step(1, pk(0,0,200,0), 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0000, "b2b3");
`else
      step(1, pk(0,0,200,0), 32'h0, 32'h0, 4'b0100, 32'h0, 4'b0000, "b2b2");
      step(1, pk(0,0,200,0), 32'h0, 32'h0, 4'b0100, 32'h0, 4'b0000, "b2b3");
`endif
      step(1, pk(50,0,0,0), 32'h0, pk(50,0,0,0), 4'b0000, 32'h0, 4'b0000, "pre_reset");

      // Mid-cycle async reset with ch0 at 50 (and ch2 refractory when built).
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("midreset_vmem", V_mem, 32'h0);
      chk("midreset_spike", {28'h0, spike}, 32'h0);
      en = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      step(1, pk(50,0,200,0), 32'h0, pk(50,0,0,0), 4'b0100, 32'h0, 4'b0000, "post_reset1");
      step(1, pk(50,0,0,0), 32'h0, pk(94,0,0,0), 4'b0000, 32'h0, 4'b0000, "post_reset2");
      step(0, 32'h0, 32'h0, pk(94,0,0,0), 4'b0000, 32'h0, 4'b0000, "final_hold");

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1, "timeout");
   end
endmodule
